// File: rtl/single_cycle_mips.sv
// rtl/single_cycle_mips.sv - single-cycle 32-bit MIPS subset CPU with PC, instruction memory, register file and data memory
module mips_pc_reg #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] next_pc,
    output logic [31:0] pc
);
    always_ff @(posedge clk) begin
        if (rst) pc <= RESET_PC;
        else     pc <= next_pc;
    end
endmodule

module mips_inst_mem #(
    parameter int WORDS = 256
) (
    input  logic [29:0] word_addr,
    output logic [31:0] instruction
);
    localparam int AW = $clog2(WORDS);

    logic [31:0] memory [0:WORDS-1];

    assign instruction = ({2'b00, word_addr} < 32'(WORDS)) ? memory[word_addr[AW-1:0]] : 32'h0;
endmodule

module mips_reg_file (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);
    logic [31:0] regs [0:31];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
        end else if (we && wa != 5'd0) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == 5'd0) ? 32'h0 : regs[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'h0 : regs[ra2];
endmodule

module mips_data_mem #(
    parameter int WORDS = 256
) (
    input  logic        clk,
    input  logic        we,
    input  logic [29:0] word_addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    localparam int AW = $clog2(WORDS);

    logic [31:0] memory [0:WORDS-1];
    logic        in_range;

    assign in_range = ({2'b00, word_addr} < 32'(WORDS));
    assign rdata    = in_range ? memory[word_addr[AW-1:0]] : 32'h0;

    always_ff @(posedge clk) begin
        if (we && in_range) memory[word_addr[AW-1:0]] <= wdata;
    end
endmodule

module single_cycle_mips #(
    parameter int          IMEM_WORDS = 256,
    parameter int          DMEM_WORDS = 256,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic clk,
    input  logic rst
);
    logic [31:0] pc, pc_plus4, next_pc, instruction;
    logic [31:0] rs_data, rt_data, imm_sext, addr_sum, mem_rdata, wd;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, wa;
    logic        reg_we, mem_we;
    logic        unused_shamt;

    assign opcode       = instruction[31:26];
    assign rs           = instruction[25:21];
    assign rt           = instruction[20:16];
    assign rd           = instruction[15:11];
    assign funct        = instruction[5:0];
    assign imm_sext     = {{16{instruction[15]}}, instruction[15:0]};
    assign unused_shamt = ^instruction[10:6];

    assign pc_plus4 = pc + 32'd4;
    assign addr_sum = rs_data + imm_sext;

    mips_pc_reg #(.RESET_PC(RESET_PC)) pc_reg (
        .clk(clk), .rst(rst), .next_pc(next_pc), .pc(pc)
    );

    mips_inst_mem #(.WORDS(IMEM_WORDS)) inst_mem (
        .word_addr(pc[31:2]), .instruction(instruction)
    );

    mips_reg_file reg_file (
        .clk(clk), .rst(rst), .ra1(rs), .ra2(rt), .rd1(rs_data), .rd2(rt_data),
        .we(reg_we), .wa(wa), .wd(wd)
    );

    // Stores are masked during reset so reset wins over an in-flight sw.
    mips_data_mem #(.WORDS(DMEM_WORDS)) data_mem (
        .clk(clk), .we(mem_we & ~rst), .word_addr(addr_sum[31:2]),
        .wdata(rt_data), .rdata(mem_rdata)
    );

    always_comb begin
        reg_we  = 1'b0;
        mem_we  = 1'b0;
        wa      = rt;
        wd      = addr_sum;
        next_pc = pc_plus4;
        case (opcode)
            6'h00: begin
                wa     = rd;
                reg_we = 1'b1;
                case (funct)
                    6'h20:   wd = rs_data + rt_data;
                    6'h22:   wd = rs_data - rt_data;
                    6'h24:   wd = rs_data & rt_data;
                    6'h25:   wd = rs_data | rt_data;
                    6'h27:   wd = ~(rs_data | rt_data);
                    6'h2A:   wd = {31'h0, $signed(rs_data) < $signed(rt_data)};
                    default: reg_we = 1'b0;
                endcase
            end
            6'h08: reg_we = 1'b1;
            6'h23: begin
                reg_we = 1'b1;
                wd     = mem_rdata;
            end
            6'h2B: mem_we = 1'b1;
            6'h04: if (rs_data == rt_data) next_pc = pc_plus4 + {imm_sext[29:0], 2'b00};
            6'h02: next_pc = {pc_plus4[31:28], instruction[25:0], 2'b00};
            default: ;
        endcase
    end
endmodule

// File: tb/tb_single_cycle_mips.sv
// tb/tb_single_cycle_mips.sv - self-checking bench: directed vector table, reset corners, random programs vs ISA model
module tb_single_cycle_mips;
    logic clk = 1'b0;
    logic rst = 1'b1;

    single_cycle_mips dut (.clk(clk), .rst(rst));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    localparam int K_REG = 0, K_PC = 1, K_MEM = 2;

    typedef struct {
        string       name;
        int          pid;
        int          cycles;
        int          kind;
        int          idx;
        logic [31:0] exp;
    } vec_t;

    logic [31:0] progs [8][10];
    logic [31:0] prog_img [256];
    vec_t        vecs [$];

    logic [31:0] m_regs [32];
    logic [31:0] m_dmem [16];
    logic [31:0] m_pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h required=%08h", name, act, exp);
        end
    endtask

    task automatic load_imem();
        for (int i = 0; i < 256; i++) dut.inst_mem.memory[i] = prog_img[i];
    endtask

    task automatic load_prog(input int pid);
        for (int i = 0; i < 256; i++) prog_img[i] = (i < 10) ? progs[pid][i] : 32'h0;
        load_imem();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    function automatic logic [31:0] sext(input logic [15:0] v);
        return 32'($signed(v));
    endfunction

    // ISA-level reference: executes one instruction word on the model state.
    task automatic model_step();
        logic [31:0] ins, a, b, res, addr;
        int          op, fn;
        ins  = (m_pc / 4 < 256) ? prog_img[m_pc / 4] : 32'h0;
        op   = int'(ins[31:26]);
        fn   = int'(ins[5:0]);
        a    = m_regs[ins[25:21]];
        b    = m_regs[ins[20:16]];
        addr = a + sext(ins[15:0]);
        m_pc = m_pc + 4;
        if (op == 0) begin
            res = 0;
            case (fn)
                32: res = a + b;
                34: res = a - b;
                36: res = a & b;
                37: res = a | b;
                39: res = ~(a | b);
                42: res = ($signed(a) < $signed(b)) ? 1 : 0;
                default: ;
            endcase
            if (fn inside {32, 34, 36, 37, 39, 42} && ins[15:11] != 0) m_regs[ins[15:11]] = res;
        end else if (op == 8) begin
            if (ins[20:16] != 0) m_regs[ins[20:16]] = addr;
        end else if (op == 35) begin
            if (ins[20:16] != 0) m_regs[ins[20:16]] = m_dmem[addr / 4];
        end else if (op == 43) begin
            m_dmem[addr / 4] = b;
        end else if (op == 4) begin
            if (a == b) m_pc = m_pc + sext(ins[15:0]) * 4;
        end
    endtask

    initial begin
        for (int p = 0; p < 8; p++)
            for (int i = 0; i < 10; i++) progs[p][i] = 32'h0;
        progs[0][0] = 32'h20010005;
        progs[1][0] = 32'h20010005; progs[1][1] = 32'h20020003; progs[1][2] = 32'h00221820;
        progs[1][3] = 32'h00222022; progs[1][4] = 32'h0022402B; progs[1][5] = 32'h00224827;
        progs[1][6] = 32'h00225024; progs[1][7] = 32'h00225825;
        progs[2][0] = 32'h2001FFFF; progs[2][1] = 32'h0020282A; progs[2][2] = 32'h20000007;
        progs[3][0] = 32'h20010005; progs[3][1] = 32'hAC010008; progs[3][2] = 32'h8C060008;
        progs[4][4] = 32'h10000002;
        progs[5][0] = 32'h20010005; progs[5][4] = 32'h10200002;
        progs[6][8] = 32'h08000000;
        progs[7][0] = 32'h20010005; progs[7][1] = 32'h20070009; progs[7][2] = 32'hAC010400;
        progs[7][3] = 32'h8C070400;

        vecs.push_back('{"addi_r1",     0, 1,  K_REG, 1,  32'd5});
        vecs.push_back('{"addi_pc",     0, 1,  K_PC,  0,  32'h4});
        vecs.push_back('{"run_past",    0, 10, K_PC,  0,  32'h28});
        vecs.push_back('{"add",         1, 4,  K_REG, 3,  32'd8});
        vecs.push_back('{"sub",         1, 4,  K_REG, 4,  32'd2});
        vecs.push_back('{"seq_pc",      1, 4,  K_PC,  0,  32'h10});
        vecs.push_back('{"bad_funct",   1, 8,  K_REG, 8,  32'h0});
        vecs.push_back('{"nor",         1, 8,  K_REG, 9,  32'hFFFFFFF8});
        vecs.push_back('{"and",         1, 8,  K_REG, 10, 32'h1});
        vecs.push_back('{"or",          1, 8,  K_REG, 11, 32'h7});
        vecs.push_back('{"addi_neg",    2, 1,  K_REG, 1,  32'hFFFFFFFF});
        vecs.push_back('{"slt_signed",  2, 2,  K_REG, 5,  32'h1});
        vecs.push_back('{"r0_write",    2, 3,  K_REG, 0,  32'h0});
        vecs.push_back('{"sw",          3, 3,  K_MEM, 2,  32'd5});
        vecs.push_back('{"lw",          3, 3,  K_REG, 6,  32'd5});
        vecs.push_back('{"beq_taken",   4, 5,  K_PC,  0,  32'h1C});
        vecs.push_back('{"beq_not",     5, 5,  K_PC,  0,  32'h14});
        vecs.push_back('{"jump",        6, 9,  K_PC,  0,  32'h0});
        vecs.push_back('{"dmem_oob",    7, 4,  K_REG, 7,  32'h0});

        load_prog(0);
        do_reset();
        check("reset_pc", dut.pc_reg.pc, 32'h0);
        check("reset_inst", dut.inst_mem.instruction, 32'h20010005);

        foreach (vecs[v]) begin
            load_prog(vecs[v].pid);
            do_reset();
            run(vecs[v].cycles);
            case (vecs[v].kind)
                K_REG:   check(vecs[v].name, dut.reg_file.regs[vecs[v].idx], vecs[v].exp);
                K_PC:    check(vecs[v].name, dut.pc_reg.pc, vecs[v].exp);
                default: check(vecs[v].name, dut.data_mem.memory[vecs[v].idx], vecs[v].exp);
            endcase
        end

        // Reset mid-program: sw at the reset edge must not land, regs clear, pc returns.
        for (int i = 0; i < 256; i++) prog_img[i] = 32'h0;
        prog_img[0] = 32'h20010005; prog_img[1] = 32'hAC01000C;
        prog_img[2] = 32'h20020003; prog_img[3] = 32'hAC02000C;
        load_imem();
        do_reset();
        run(3);
        check("midrst_pre_pc", dut.pc_reg.pc, 32'hC);
        check("midrst_pre_mem", dut.data_mem.memory[3], 32'd5);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_pc", dut.pc_reg.pc, 32'h0);
        check("midrst_r1", dut.reg_file.regs[1], 32'h0);
        check("midrst_r2", dut.reg_file.regs[2], 32'h0);
        check("midrst_sw_suppressed", dut.data_mem.memory[3], 32'd5);
        rst = 1'b0;
        run(1);
        check("midrst_restart_pc", dut.pc_reg.pc, 32'h4);

        // Random programs against the ISA model.
        for (int t = 0; t < 4; t++) begin
            int funcs [8] = '{32, 34, 36, 37, 39, 42, 0, 33};
            for (int i = 0; i < 256; i++) prog_img[i] = 32'h0;
            for (int k = 0; k < 16; k++) prog_img[k] = {6'h2B, 5'd0, 5'd0, 16'(k * 4)};
            for (int k = 16; k < 70; k++) begin
                logic [4:0] r1, r2, r3;
                r1 = 5'($urandom_range(0, 7));
                r2 = 5'($urandom_range(0, 7));
                r3 = 5'($urandom_range(0, 7));
                case ($urandom_range(0, 5))
                    0, 1: prog_img[k] = {6'h08, r1, r2, 16'($urandom)};
                    2:    prog_img[k] = {6'h00, r1, r2, r3, 5'd0, 6'(funcs[$urandom_range(0, 7)])};
                    3:    prog_img[k] = {6'h23, 5'd0, r2, 16'($urandom_range(0, 15) * 4)};
                    4:    prog_img[k] = {6'h2B, 5'd0, r2, 16'($urandom_range(0, 15) * 4)};
                    default: prog_img[k] = {6'h04, r1, r2, 16'($urandom_range(0, 3))};
                endcase
            end
            load_imem();
            do_reset();
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
            for (int i = 0; i < 16; i++) m_dmem[i] = 32'h0;
            m_pc = 32'h0;
            for (int c = 0; c < 90; c++) begin
                model_step();
                @(posedge clk); #1;
                if (dut.pc_reg.pc !== m_pc) check($sformatf("rand%0d_pc_c%0d", t, c), dut.pc_reg.pc, m_pc);
            end
            check($sformatf("rand%0d_pc_end", t), dut.pc_reg.pc, m_pc);
            for (int r = 0; r < 8; r++)
                check($sformatf("rand%0d_reg%0d", t, r), dut.reg_file.regs[r], m_regs[r]);
            for (int w = 0; w < 16; w++)
                check($sformatf("rand%0d_dmem%0d", t, w), dut.data_mem.memory[w], m_dmem[w]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
